// File: rtl/register_file_sb.sv
// Multi-port register file with per-register pending-write counters for hazard tracking.
// Read ports and reservation handshake are combinational; state updates on the rising edge.
module register_file_sb #(
    parameter int unsigned        LEN_REG      = 32,
    parameter int unsigned        NUM_REGS     = 16,
    parameter int unsigned        LEN_REG_ADDR = 4,
    parameter int unsigned        NUM_RD       = 2,
    parameter int unsigned        NUM_WB       = 2,
    parameter int unsigned        LEN_PEND     = 2,
    parameter bit                 BYPASS       = 1'b1,
    parameter bit                 ZERO_REG     = 1'b1,
    parameter logic [LEN_REG-1:0] INITIAL_DATA = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RD*LEN_REG_ADDR-1:0]   rd_addr_i,
    output logic [NUM_RD*LEN_REG-1:0]        rd_data_o,
    output logic [NUM_RD-1:0]                rd_busy_o,
    input  logic                             rsv_valid_i,
    input  logic [LEN_REG_ADDR-1:0]          rsv_addr_i,
    output logic                             rsv_ready_o,
    input  logic [NUM_WB-1:0]                wb_valid_i,
    input  logic [NUM_WB*LEN_REG_ADDR-1:0]   wb_addr_i,
    input  logic [NUM_WB*LEN_REG-1:0]        wb_data_i
);
    localparam int unsigned   CNT_W    = $clog2(NUM_WB + 1);
    localparam int unsigned   SUM_W    = ((LEN_PEND > CNT_W) ? LEN_PEND : CNT_W) + 1;
    localparam logic [LEN_PEND-1:0] PEND_MAX = '1;

    logic [LEN_REG-1:0]  data_q    [NUM_REGS];
    logic [LEN_PEND-1:0] pend_q    [NUM_REGS];
    logic [LEN_PEND-1:0] pend_next [NUM_REGS];
    logic [CNT_W-1:0]    nwb       [NUM_REGS];
    logic [LEN_REG-1:0]  wb_sel    [NUM_REGS];
    logic [LEN_REG-1:0]  rd_view   [NUM_REGS];
    logic [NUM_REGS-1:0] busy_view;
    logic [NUM_REGS-1:0] live;
    logic [NUM_REGS-1:0] rsv_hit;
    logic                rsv_blocked;

    // A register is live unless it is the hard-wired zero register.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            live[r] = !(ZERO_REG && (r == 0));
        end
    end

    // Per-register write-back match count and winning data (highest port wins).
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            nwb[r]    = '0;
            wb_sel[r] = data_q[r];
            for (int j = 0; j < NUM_WB; j++) begin
                if (wb_valid_i[j] && (wb_addr_i[j*LEN_REG_ADDR +: LEN_REG_ADDR] == LEN_REG_ADDR'(r))) begin
                    nwb[r]    = nwb[r] + CNT_W'(1);
                    wb_sel[r] = wb_data_i[j*LEN_REG +: LEN_REG];
                end
            end
        end
    end

    // What a read port sees for each register this cycle.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!live[r]) begin
                rd_view[r]   = '0;
                busy_view[r] = 1'b0;
            end else if (BYPASS) begin
                rd_view[r]   = wb_sel[r];
                busy_view[r] = SUM_W'(pend_q[r]) > SUM_W'(nwb[r]);
            end else begin
                rd_view[r]   = data_q[r];
                busy_view[r] = pend_q[r] != '0;
            end
        end
    end

    // Read ports; unmapped addresses fall through to zero / not busy.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rd_addr_i[k*LEN_REG_ADDR +: LEN_REG_ADDR] == LEN_REG_ADDR'(r)) begin
                    rd_data_o[k*LEN_REG +: LEN_REG] = rd_view[r];
                    rd_busy_o[k]                    = busy_view[r];
                end
            end
        end
    end

    // Reservation is refused only when the counter is saturated and no write-back frees a slot.
    always_comb begin
        rsv_blocked = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (live[r] && (rsv_addr_i == LEN_REG_ADDR'(r)) && (pend_q[r] == PEND_MAX) && (nwb[r] == '0)) begin
                rsv_blocked = 1'b1;
            end
        end
        rsv_ready_o = ~rsv_valid_i | ~rsv_blocked;
        for (int r = 0; r < NUM_REGS; r++) begin
            rsv_hit[r] = rsv_valid_i & ~rsv_blocked & live[r] & (rsv_addr_i == LEN_REG_ADDR'(r));
        end
    end

    // Pending count: add accepted reservation, retire write-backs, floor at zero.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if ((SUM_W'(pend_q[r]) + SUM_W'(rsv_hit[r])) > SUM_W'(nwb[r])) begin
                pend_next[r] = LEN_PEND'(SUM_W'(pend_q[r]) + SUM_W'(rsv_hit[r]) - SUM_W'(nwb[r]));
            end else begin
                pend_next[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                data_q[r] <= INITIAL_DATA;
                pend_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (live[r]) begin
                    pend_q[r] <= pend_next[r];
                    if (nwb[r] != '0) begin
                        data_q[r] <= wb_sel[r];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: one bypassing and one non-bypassing instance
// driven by the same stimulus, checked against hand-computed values.
module tb_register_file_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic        rsv_valid;
    logic [3:0]  rsv_addr;
    logic        rsv_ready_b, rsv_ready_n;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_addr;
    logic [63:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    register_file_sb #(.BYPASS(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready_b),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data)
    );

    register_file_sb #(.BYPASS(1'b0)) dut_n (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready_n),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rsv_valid = 1'b0;
        rsv_addr  = 4'd0;
        wb_valid  = 2'b00;
        wb_addr   = 8'd0;
        wb_data   = 64'd0;
    endtask

    // Advance to just after the next rising edge and clear the one-shot inputs.
    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input int port, input logic [3:0] addr);
        rd_addr[port*4 +: 4] = addr;
    endtask

    task automatic rsv(input logic [3:0] addr);
        rsv_valid = 1'b1;
        rsv_addr  = addr;
    endtask

    task automatic wb(input int port, input logic [3:0] addr, input logic [31:0] data);
        wb_valid[port]          = 1'b1;
        wb_addr[port*4 +: 4]    = addr;
        wb_data[port*32 +: 32]  = data;
    endtask

    initial begin
        idle();
        rd_addr = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state across all registers, both read ports.
        for (int i = 0; i < 16; i++) begin
            next();
            rd(0, 4'(i));
            rd(1, 4'(15 - i));
            #1;
            check("rst_data_p0", rd_data_b[31:0], 32'h0);
            check("rst_busy_p0", 32'(rd_busy_b[0]), 32'h0);
            check("rst_data_p1", rd_data_n[63:32], 32'h0);
            check("rst_busy_p1", 32'(rd_busy_n[1]), 32'h0);
        end
        check("rst_ready", 32'(rsv_ready_b), 32'h1);

        // Reserve r3, write it back two cycles later.
        next(); rd(0, 4'd3); rsv(4'd3); #1;
        check("r3_c0_ready", 32'(rsv_ready_b), 32'h1);
        check("r3_c0_busy_b", 32'(rd_busy_b[0]), 32'h0);
        check("r3_c0_busy_n", 32'(rd_busy_n[0]), 32'h0);
        next(); #1;
        check("r3_c1_busy_b", 32'(rd_busy_b[0]), 32'h1);
        check("r3_c1_busy_n", 32'(rd_busy_n[0]), 32'h1);
        next(); wb(0, 4'd3, 32'hDEADBEEF); #1;
        check("r3_c2_data_b", rd_data_b[31:0], 32'hDEADBEEF);
        check("r3_c2_busy_b", 32'(rd_busy_b[0]), 32'h0);
        check("r3_c2_data_n", rd_data_n[31:0], 32'h0);
        check("r3_c2_busy_n", 32'(rd_busy_n[0]), 32'h1);
        next(); #1;
        check("r3_c3_data_n", rd_data_n[31:0], 32'hDEADBEEF);
        check("r3_c3_busy_n", 32'(rd_busy_n[0]), 32'h0);
        check("r3_c3_busy_b", 32'(rd_busy_b[0]), 32'h0);

        // Saturate r5's counter, then drain it.
        rd(1, 4'd5);
        for (int i = 0; i < 3; i++) begin
            next(); rsv(4'd5); #1;
            check("r5_rsv_ready", 32'(rsv_ready_b), 32'h1);
        end
        next(); rsv(4'd5); #1;
        check("r5_full_ready_b", 32'(rsv_ready_b), 32'h0);
        check("r5_full_ready_n", 32'(rsv_ready_n), 32'h0);
        check("r5_full_busy_b", 32'(rd_busy_b[1]), 32'h1);
        next(); rsv(4'd5); wb(1, 4'd5, 32'h11); #1;
        check("r5_swap_ready_b", 32'(rsv_ready_b), 32'h1);
        check("r5_swap_ready_n", 32'(rsv_ready_n), 32'h1);
        check("r5_swap_busy_b", 32'(rd_busy_b[1]), 32'h1);
        check("r5_swap_data_b", rd_data_b[63:32], 32'h11);
        next(); rsv(4'd5); #1;
        check("r5_still_full", 32'(rsv_ready_b), 32'h0);
        next(); wb(0, 4'd5, 32'h21); #1;
        next(); wb(1, 4'd5, 32'h22); #1;
        check("r5_wb2_busy_n", 32'(rd_busy_n[1]), 32'h1);
        check("r5_wb2_busy_b", 32'(rd_busy_b[1]), 32'h1);
        next(); wb(0, 4'd5, 32'h23); #1;
        check("r5_wb3_busy_b", 32'(rd_busy_b[1]), 32'h0);
        check("r5_wb3_data_b", rd_data_b[63:32], 32'h23);
        check("r5_wb3_busy_n", 32'(rd_busy_n[1]), 32'h1);
        next(); #1;
        check("r5_done_busy_n", 32'(rd_busy_n[1]), 32'h0);
        check("r5_done_data_n", rd_data_n[63:32], 32'h23);

        // Two write-back ports hit r7 together; port 1 wins.
        rd(0, 4'd7);
        next(); rsv(4'd7);
        next(); rsv(4'd7);
        next(); wb(0, 4'd7, 32'h1); wb(1, 4'd7, 32'h2); #1;
        check("r7_dual_data_b", rd_data_b[31:0], 32'h2);
        check("r7_dual_busy_b", 32'(rd_busy_b[0]), 32'h0);
        check("r7_dual_data_n", rd_data_n[31:0], 32'h0);
        check("r7_dual_busy_n", 32'(rd_busy_n[0]), 32'h1);
        next(); #1;
        check("r7_after_data_n", rd_data_n[31:0], 32'h2);
        check("r7_after_busy_n", 32'(rd_busy_n[0]), 32'h0);
        check("r7_after_busy_b", 32'(rd_busy_b[0]), 32'h0);

        // Register 0 is hard-wired zero.
        rd(0, 4'd0);
        next(); wb(0, 4'd0, 32'hFFFF); rsv(4'd0); #1;
        check("r0_ready", 32'(rsv_ready_b), 32'h1);
        check("r0_data_b", rd_data_b[31:0], 32'h0);
        check("r0_busy_b", 32'(rd_busy_b[0]), 32'h0);
        next(); #1;
        check("r0_next_data_n", rd_data_n[31:0], 32'h0);
        check("r0_next_busy_n", 32'(rd_busy_n[0]), 32'h0);
        check("r0_next_busy_b", 32'(rd_busy_b[0]), 32'h0);

        // Asynchronous reset with r9 reserved, then a late write-back acts as a preload.
        rd(0, 4'd9); rd(1, 4'd3);
        next(); rsv(4'd9);
        next(); #1;
        check("r9_busy_pre", 32'(rd_busy_b[0]), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("r9_rst_busy_b", 32'(rd_busy_b[0]), 32'h0);
        check("r9_rst_busy_n", 32'(rd_busy_n[0]), 32'h0);
        check("r3_rst_data", rd_data_b[63:32], 32'h0);
        next(); rst = 1'b1; wb(0, 4'd9, 32'h55); #1;
        check("r9_pre_data_b", rd_data_b[31:0], 32'h55);
        check("r9_pre_busy_b", 32'(rd_busy_b[0]), 32'h0);
        next(); rsv(4'd9); #1;
        check("r9_pre_data_n", rd_data_n[31:0], 32'h55);
        check("r9_pre_busy_n", 32'(rd_busy_n[0]), 32'h0);
        next(); wb(0, 4'd9, 32'h66); #1;
        check("r9_one_busy_n", 32'(rd_busy_n[0]), 32'h1);
        check("r9_one_busy_b", 32'(rd_busy_b[0]), 32'h0);
        next(); #1;
        check("r9_end_busy_n", 32'(rd_busy_n[0]), 32'h0);
        check("r9_end_data_n", rd_data_n[31:0], 32'h66);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/register_file_sb.md
# register_file_sb

Multi-entry register file with a built-in write-reservation scoreboard. It is the parametrised successor of the single register cell. It holds NUM_REGS architectural registers and serves NUM_RD combinational read ports and NUM_WB write-back ports. Each register carries a pending-write counter instead of a single reserve bit, so several in-flight writes to one register (WAW) are tracked. Issue logic uses it for operand fetch and hazard checks, and execution units retire into it.

## Interface
- LEN_REG, 32, register data width.
- NUM_REGS, 16, number of registers.
- LEN_REG_ADDR, 4, address width; ceil(log2(NUM_REGS)) or wider.
- NUM_RD, 2, read ports.
- NUM_WB, 2, write-back ports.
- LEN_PEND, 2, pending counter width; max outstanding writes per register is 2^LEN_PEND-1.
- BYPASS, 1, 1 = forward same-cycle write-back data to read ports.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and reservations.
- INITIAL_DATA, {LEN_REG{1'b0}}, reset value of every register.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rd_addr_i  in  NUM_RD*LEN_REG_ADDR  read addresses, port k at slice k.
- rd_data_o  out  NUM_RD*LEN_REG  read data.
- rd_busy_o  out  NUM_RD  1 = operand not yet valid (pending write outstanding).
- rsv_valid_i  in  1  reserve request: one future write to rsv_addr_i.
- rsv_addr_i  in  LEN_REG_ADDR  register to reserve.
- rsv_ready_o  out  1  reservation accepted this cycle.
- wb_valid_i  in  NUM_WB  write-back strobes.
- wb_addr_i  in  NUM_WB*LEN_REG_ADDR  write-back addresses.
- wb_data_i  in  NUM_WB*LEN_REG  write-back data.

## Operation
- State per register r: data[r] (LEN_REG bits) and pend[r] (LEN_PEND bits).
- Reset (rst low, async): data[r] = INITIAL_DATA, pend[r] = 0 for all r.
- Outputs at reset: rd_busy_o = 0, rd_data_o = INITIAL_DATA (0 for reg 0 when ZERO_REG = 1), rsv_ready_o = 1.
- Read, combinational:
  - rd_data_o[k] = data[a]. With BYPASS = 1 and any valid wb port matching a, rd_data_o[k] takes that port's data; the highest-index matching port wins.
- rd_busy_o[k] = (pend[a] != 0). With BYPASS = 1, busy is cleared when pend[a] minus the number of matching wb ports this cycle reaches 0.
- A reservation in the same cycle never affects same-cycle read outputs.
- rsv_ready_o = ~rsv_valid_i | (pend[rsv_addr_i] != max) | (some wb matches rsv_addr_i this cycle).
  - A request with rsv_ready_o = 0 is not taken and pend does not change. The requester holds it.
- Update at the edge, per register r:
  - nwb = number of valid wb ports with address r.
  - inc = rsv_valid_i & rsv_ready_o & rsv_addr_i == r.
  - pend[r] <= pend[r] + inc - nwb, floored at 0. Reserve plus one write-back in the same cycle leaves pend unchanged.
  - If nwb > 0, data[r] <= wb_data of the highest-index matching port.
- A write-back to a register with pend = 0 (e.g. preload) is legal: data is written and pend stays 0.
- ZERO_REG = 1 and address 0: reads return 0, busy = 0, writes are discarded, reservations are accepted (ready = 1) and not counted.
- Addresses >= NUM_REGS: reads return 0 with busy = 0, writes and reservations are ignored, ready = 1.

## Timing
- Read path is purely combinational from rd_addr_i, the registered state, and (if BYPASS = 1) wb_*.
- Write visibility: with BYPASS = 1, data is visible in the same cycle; otherwise it is visible the cycle after the edge.
- Reservation: pend increments at the edge, so rd_busy_o rises the following cycle.
- rsv_ready_o depends combinationally on rsv_addr_i, pend and wb_*. There is no path from rd_addr_i.
- Reset mid-operation: all pending counts clear immediately, asynchronously. In-flight write-backs arriving after reset deassertion are treated as preload writes.

## Test plan
- Reset, then read regs 0..15 -> data 0, busy 0, rsv_ready_o 1.
- Reserve r3 at cycle 0, wb r3 = 0xDEADBEEF at cycle 2:
  - BYPASS = 0: busy on r3 in cycles 1-2, data 0xDEADBEEF and busy 0 from cycle 3.
  - BYPASS = 1: data 0xDEADBEEF and busy 0 in cycle 2.
- Reserve r5 three times (LEN_PEND = 2):
  - A fourth request gets rsv_ready_o = 0.
  - The same request plus a wb r5 in one cycle is accepted and pend stays 3.
  - Three further wbs then clear busy.
- Both wb ports hit r7 in one cycle with 0x1 (port 0) and 0x2 (port 1), pend = 2 -> data 0x2, pend 0, busy 0 next cycle.
- ZERO_REG = 1: wb r0 = 0xFFFF and reserve r0 -> r0 still reads 0 with busy 0.
- Reserve r9, assert rst low mid-cycle -> busy drops immediately. A later wb r9 = 0x55 leaves pend 0 and data 0x55.
